// File: rtl/iir_pkg.sv
// Shared constants and capture-state encoding for the IIR filter datapath and its capture wrapper.
package iir_pkg;

    localparam int IIR_DW      = 32;
    localparam int IIR_DEPTH   = 32;
    localparam int IIR_AW      = $clog2(IIR_DEPTH);
    localparam int IIR_LATENCY = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } cap_state_e;

endpackage

// File: rtl/iir_capture_ram.sv
// DEPTH x DW sample buffer: one synchronous write port, one asynchronous read port, no reset.
module iir_capture_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iir_out_capture.sv
// Captures DEPTH filter output samples after a LATENCY-cycle wait following each start pulse.
module iir_out_capture
    import iir_pkg::*;
#(
    parameter int DW      = IIR_DW,
    parameter int DEPTH   = IIR_DEPTH,
    parameter int AW      = IIR_AW,
    parameter int LATENCY = IIR_LATENCY
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [DW-1:0] in_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   sample_cnt_o
);

    localparam int CW = AW + 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    cap_state_e    state_q, state_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic          wr_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // start_i overrides every state, including an in-flight capture
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        sample_cnt_d = sample_cnt_q;
        if (start_i) begin
            lat_cnt_d    = LW'(LATENCY - 1);
            sample_cnt_d = '0;
            state_d      = (LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                    if (lat_cnt_q == LW'(1)) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    sample_cnt_d = sample_cnt_q + CW'(1);
                    if (sample_cnt_q == CW'(DEPTH - 1)) state_d = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en  = (state_q == ST_CAPTURE) && !start_i;
        busy_o = (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
        done_o = (state_q == ST_DONE);
    end

    assign sample_cnt_o = sample_cnt_q;

    iir_capture_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (sample_cnt_q[AW-1:0]),
        .wdata_i (in_data_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

endmodule

// File: tb/tb_iir_out_capture.sv
// Bench for iir_out_capture: a LATENCY=8 and a LATENCY=1 instance against a timestamp-based model.
module tb_iir_out_capture;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    typedef struct {
        int          inst;
        int          addr;
        logic [31:0] exp;
    } rd_vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    start;
    logic [DW-1:0] in_data;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          busy0, busy1, done0, done1;
    logic [AW:0]   cnt0, cnt1;

    always #5 clk = ~clk;

    iir_out_capture #(.DW(DW), .DEPTH(D), .AW(AW), .LATENCY(8)) dut (
        .clk(clk), .reset(reset), .start_i(start[0]), .in_data_i(in_data),
        .rd_addr_i(rd_addr0), .rd_data_o(rd_data0), .busy_o(busy0),
        .done_o(done0), .sample_cnt_o(cnt0)
    );

    iir_out_capture #(.DW(DW), .DEPTH(D), .AW(AW), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start[1]), .in_data_i(in_data),
        .rd_addr_i(rd_addr1), .rd_data_o(rd_data1), .busy_o(busy1),
        .done_o(done1), .sample_cnt_o(cnt1)
    );

    // model: a run is just "start seen at cycle tstart"; everything else follows arithmetically
    bit          act [2];
    int          tstart [2];
    logic [31:0] em [2][D];
    int          cyc, nvec, nerr;
    rd_vec_t     tbl[$];

    function automatic int lat_of(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_ctrl();
        for (int i = 0; i < 2; i++) begin
            int L, rel, ecnt;
            logic eb, ed;
            L = lat_of(i);
            eb = 1'b0; ed = 1'b0; ecnt = 0;
            if (act[i]) begin
                rel  = cyc - tstart[i];
                eb   = (rel >= 1) && (rel <= L + D - 1);
                ed   = (rel >= L + D);
                ecnt = rel - L;
                if (ecnt < 0) ecnt = 0;
                if (ecnt > D) ecnt = D;
            end
            check($sformatf("busy%0d", i), (i == 0) ? busy0 : busy1, eb);
            check($sformatf("done%0d", i), (i == 0) ? done0 : done1, ed);
            check($sformatf("cnt%0d", i),  (i == 0) ? cnt0 : cnt1, ecnt);
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                if (start[i]) begin
                    act[i] = 1'b1;
                    tstart[i] = cyc;
                end else if (act[i]) begin
                    int rel;
                    rel = cyc - tstart[i];
                    if (rel >= lat_of(i) && rel < lat_of(i) + D) em[i][rel - lat_of(i)] = in_data;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        start = 2'b00;
        chk_ctrl();
    endtask

    task automatic chk_rd(input int i, input int a, input logic [31:0] exp);
        if (i == 0) rd_addr0 = AW'(a);
        else        rd_addr1 = AW'(a);
        #1;
        check($sformatf("rd%0d[%0d]", i, a), (i == 0) ? rd_data0 : rd_data1, exp);
    endtask

    task automatic sweep(input int i);
        for (int a = 0; a < D; a++) begin
            chk_rd(i, a, em[i][a]);
            tick();
        end
    endtask

    task automatic run(input int n, input int inst, input int restart_at);
        for (int j = 0; j < n; j++) begin
            in_data = $urandom;
            if (j == 0 || j == restart_at) start[inst] = 1'b1;
            tick();
        end
    endtask

    initial begin
        int busy_cnt;
        nvec = 0; nerr = 0; cyc = 0;
        start = 2'b00; in_data = '0; rd_addr0 = '0; rd_addr1 = '0;
        act[0] = 1'b0; act[1] = 1'b0;

        for (int k = 0; k < D; k++) tbl.push_back('{0, k, 32'(8 + k)});
        tbl.push_back('{1, 0,  32'hA001});
        tbl.push_back('{1, 1,  32'hA002});
        tbl.push_back('{1, 15, 32'hA010});
        tbl.push_back('{1, 31, 32'hA020});

        // reset state
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_ctrl();
        tick(); tick();
        reset = 1'b1;
        tick();

        // basic run, in_data = cycle count from the start cycle
        busy_cnt = 0;
        for (int j = 0; j < 45; j++) begin
            in_data = 32'(j);
            if (j == 0) start[0] = 1'b1;
            tick();
            if (busy0) busy_cnt++;
        end
        check("busy0_cycles", busy_cnt, 39);

        // LATENCY=1 run, in_data = 0xA000 + cycle
        for (int j = 0; j < 36; j++) begin
            in_data = 32'hA000 + 32'(j);
            if (j == 0) start[1] = 1'b1;
            tick();
        end

        for (int v = 0; v < tbl.size(); v++) begin
            chk_rd(tbl[v].inst, tbl[v].addr, tbl[v].exp);
            tick();
        end

        // done holds while idle
        for (int j = 0; j < 100; j++) begin
            in_data = $urandom;
            tick();
        end
        check("done0_hold", done0, 1'b1);

        // restart mid-capture
        run(66, 0, 20);
        sweep(0);

        // reset mid-run, then restart
        run(15, 0, -1);
        reset = 1'b0;
        act[0] = 1'b0; act[1] = 1'b0;
        #1 chk_ctrl();
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();
        for (int a = 0; a < 7; a++) begin
            chk_rd(0, a, em[0][a]);
            tick();
        end
        run(45, 0, -1);
        sweep(0);

        // start coincident with the final capture write
        run(40, 0, 39);
        chk_rd(0, 31, em[0][31]);
        check("done0_after_late_start", done0, 1'b0);
        for (int j = 0; j < 45; j++) begin
            in_data = $urandom;
            tick();
        end
        sweep(0);

        // random starts on both instances
        for (int j = 0; j < 400; j++) begin
            in_data = $urandom;
            start[0] = ($urandom_range(0, 39) == 0);
            start[1] = ($urandom_range(0, 39) == 0);
            tick();
        end
        for (int j = 0; j < 50; j++) begin
            in_data = $urandom;
            tick();
        end
        sweep(0);
        sweep(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
